// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the Booth multiplier: FSM state encoding, default width
// and the Booth add/sub/nop select derived from the {Qr[0], q_m1} bit pair.
package mult_pkg;

  localparam int MULT_WIDTH = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_sel_t;

  // Pair 01 ends a run of ones (add M), pair 10 starts one (subtract M).
  function automatic booth_sel_t booth_select(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Request/result bundle between the EX-stage issue logic (master) and the
// Booth multiplier (slave).
//
// Handshake: start is sampled only while the multiplier is idle; operands are
// captured on that edge. busy is high while iterating. ready is a level: once
// high, result is valid and held until the next accepted start, after which
// ready drops and result keeps its old value until the new completion.
interface booth_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, ready, result
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, ready, result
  );
endinterface

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth iteration: optional add/sub of M into A, then an
// arithmetic right shift of the concatenation {A, Qr, q_m1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] qr,
  input  logic             q_m1,
  input  logic [WIDTH:0]   mr,
  input  booth_sel_t       sel,
  output logic [WIDTH:0]   a_new,
  output logic [WIDTH-1:0] qr_new,
  output logic             q_m1_new
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = a;
    case (sel)
      BOOTH_ADD: sum = a + mr;
      BOOTH_SUB: sum = a - mr;
      default:   sum = a;
    endcase
    // A carries a guard bit so subtracting -2^(WIDTH-1) cannot overflow.
    a_new    = {sum[WIDTH], sum[WIDTH:1]};
    qr_new   = {sum[0], qr[WIDTH-1:1]};
    q_m1_new = qr[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier, one iteration per cycle.
// Optional macro MULT_EARLY_EXIT_EN finishes as soon as no further add/sub can occur.
module booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_multiplier_if.slave    bus,
  output state_t               dbg_state
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     qr_q, qr_d;
  logic                 q_m1_q, q_m1_d;
  logic [WIDTH:0]       mr_q, mr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH:0]       a_new;
  logic [WIDTH-1:0]     qr_new;
  logic                 q_m1_new;
  logic [CNT_W-1:0]     cnt_next;
  logic                 done;
  logic [2*WIDTH-1:0]   result_fin;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a_q),
    .qr       (qr_q),
    .q_m1     (q_m1_q),
    .mr       (mr_q),
    .sel      (booth_select(qr_q[0], q_m1_q)),
    .a_new    (a_new),
    .qr_new   (qr_new),
    .q_m1_new (q_m1_new)
  );

  assign cnt_next = cnt_q + 1'b1;

`ifdef MULT_EARLY_EXIT_EN
  logic                     all_ones;
  logic                     all_zeros;
  logic signed [2*WIDTH-1:0] early_prod;

  // Unconsumed multiplier bits plus q_m1 all equal: only shifts remain, so the
  // partial product already in {A, Qr} just needs sign extension.
  always_comb begin
    all_ones  = q_m1_new;
    all_zeros = ~q_m1_new;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < WIDTH - int'(cnt_next)) begin
        all_ones  = all_ones & qr_new[i];
        all_zeros = all_zeros & ~qr_new[i];
      end
    end
    early_prod = $signed({a_new[WIDTH-1:0], qr_new}) >>> (WIDTH - int'(cnt_next));
    done       = all_ones | all_zeros | (cnt_q == LAST_ITER);
    result_fin = early_prod;
  end
`else
  always_comb begin
    done       = (cnt_q == LAST_ITER);
    result_fin = {a_new[WIDTH-1:0], qr_new};
  end
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    qr_d     = qr_q;
    q_m1_d   = q_m1_q;
    mr_d     = mr_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = '0;
          qr_d    = bus.multiplier;
          q_m1_d  = 1'b0;
          mr_d    = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = '0;
          ready_d = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d    = a_new;
        qr_d   = qr_new;
        q_m1_d = q_m1_new;
        cnt_d  = cnt_next;
        if (done) begin
          result_d = result_fin;
          ready_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      qr_q     <= '0;
      q_m1_q   <= 1'b0;
      mr_q     <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      qr_q     <= qr_d;
      q_m1_q   <= q_m1_d;
      mr_q     <= mr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.ready  = ready_q;
  assign bus.result = result_q;
  assign dbg_state  = state_q;

endmodule
